// File: rtl/spi_shift_engine_pkg.sv
// Shared definitions for the SPI shift engine: FSM state encodings, mode bit
// positions and the SCLK sample-edge classifier.
package spi_shift_engine_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // Bit positions inside the latched 2-bit mode word.
  localparam int MODE_CPHA = 0;
  localparam int MODE_CPOL = 1;

  // A leading edge leaves the idle level; the sample edge is the one the
  // generator does not flag: leading for CPHA=0, trailing for CPHA=1.
  function automatic logic is_sample_edge(input logic sclk, input logic sclk_dly,
                                          input logic cpol, input logic cpha);
    logic leading;
    leading = (sclk_dly == cpol);
    return (sclk ^ sclk_dly) && (leading != cpha);
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI master transfer controller: frames CS_n, enables the external SCLK
// generator, shifts MOSI on its flag pulses and samples MISO on the other edge.
module spi_shift_engine
  import spi_shift_engine_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Start,
  input  logic [DATA_W-1:0] TxData,
  input  logic              CPOL,
  input  logic              CPHA,
  input  logic              SCLK,
  input  logic              ClkCntFlg,
  input  logic              MISO,
  output logic              ClkCntEn,
  output logic              CpolOut,
  output logic              CphaOut,
  output logic              MOSI,
  output logic              CS_n,
  output logic [DATA_W-1:0] RxData,
  output logic              Done,
  output logic              Busy
);

  localparam int CNT_W   = $clog2(DATA_W + 1);
  localparam int DLY_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int DLY_W   = $clog2(DLY_MAX + 1);

  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] BIT_MAX    = CNT_W'(DATA_W);
  localparam logic [DLY_W-1:0] SETUP_LAST = DLY_W'(CS_SETUP - 1);
  localparam logic [DLY_W-1:0] HOLD_LAST  = DLY_W'(CS_HOLD - 1);

  logic [1:0]        state_q,      state_d;
  logic [1:0]        mode_q,       mode_d;
  logic [DATA_W-1:0] tx_shift_q,   tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q,   rx_shift_d;
  logic [DATA_W-1:0] rx_data_q,    rx_data_d;
  logic [CNT_W-1:0]  flg_cnt_q,    flg_cnt_d;
  logic [CNT_W-1:0]  smp_cnt_q,    smp_cnt_d;
  logic [DLY_W-1:0]  dly_cnt_q,    dly_cnt_d;
  logic              cs_n_q,       cs_n_d;
  logic              clk_cnt_en_q, clk_cnt_en_d;
  logic              done_q,       done_d;
  logic              sclk_dly_q;

  logic sample_edge;
  logic last_edge;
  logic cpha;

  assign cpha        = mode_q[MODE_CPHA];
  assign sample_edge = is_sample_edge(SCLK, sclk_dly_q, mode_q[MODE_CPOL], cpha);

  always_comb begin
    // NOTE: every signal assigned here gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    mode_d       = mode_q;
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data_q;
    flg_cnt_d    = flg_cnt_q;
    smp_cnt_d    = smp_cnt_q;
    dly_cnt_d    = dly_cnt_q;
    cs_n_d       = cs_n_q;
    clk_cnt_en_d = clk_cnt_en_q;
    done_d       = 1'b0;
    last_edge    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          tx_shift_d        = TxData;
          mode_d[MODE_CPOL] = CPOL;
          mode_d[MODE_CPHA] = CPHA;
          rx_shift_d        = '0;
          flg_cnt_d         = '0;
          smp_cnt_d         = '0;
          dly_cnt_d         = '0;
          cs_n_d            = 1'b0;
          state_d           = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (dly_cnt_q == SETUP_LAST) begin
          dly_cnt_d    = '0;
          clk_cnt_en_d = 1'b1;
          state_d      = ST_SHIFT;
        end else begin
          dly_cnt_d = dly_cnt_q + DLY_W'(1);
        end
      end

      ST_SHIFT: begin
        if (sample_edge) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], MISO};
          if (smp_cnt_q != BIT_MAX) smp_cnt_d = smp_cnt_q + CNT_W'(1);
        end
        // With CPHA=1 the MSB is already on MOSI, so the first flag only
        // marks the leading edge and must not shift.
        if (ClkCntFlg) begin
          if (flg_cnt_q != BIT_MAX) flg_cnt_d = flg_cnt_q + CNT_W'(1);
          if (!(cpha && flg_cnt_q == '0)) tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
        end
        last_edge = cpha ? (sample_edge && smp_cnt_q == LAST_BIT)
                         : (ClkCntFlg && flg_cnt_q == LAST_BIT);
        if (last_edge) begin
          clk_cnt_en_d = 1'b0;
          dly_cnt_d    = '0;
          state_d      = ST_HOLD;
        end
      end

      ST_HOLD: begin
        // The received word already sits in rx_shift_q; publish it with Done.
        if (dly_cnt_q == HOLD_LAST) begin
          cs_n_d    = 1'b1;
          done_d    = 1'b1;
          rx_data_d = rx_shift_q;
          state_d   = ST_IDLE;
        end else begin
          dly_cnt_d = dly_cnt_q + DLY_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= '0;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      flg_cnt_q    <= '0;
      smp_cnt_q    <= '0;
      dly_cnt_q    <= '0;
      cs_n_q       <= 1'b1;
      clk_cnt_en_q <= 1'b0;
      done_q       <= 1'b0;
      sclk_dly_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // values, independent of statement order in this block.
      state_q      <= state_d;
      mode_q       <= mode_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      flg_cnt_q    <= flg_cnt_d;
      smp_cnt_q    <= smp_cnt_d;
      dly_cnt_q    <= dly_cnt_d;
      cs_n_q       <= cs_n_d;
      clk_cnt_en_q <= clk_cnt_en_d;
      done_q       <= done_d;
      sclk_dly_q   <= SCLK;
    end
  end

  assign ClkCntEn = clk_cnt_en_q;
  assign CpolOut  = mode_q[MODE_CPOL];
  assign CphaOut  = mode_q[MODE_CPHA];
  assign MOSI     = tx_shift_q[DATA_W-1];
  assign CS_n     = cs_n_q;
  assign RxData   = rx_data_q;
  assign Done     = done_q;
  assign Busy     = (state_q != ST_IDLE);

endmodule
